register_bit: RTL and testbench

REGISTER_BIT -- requirements
Module: register_bit

---
 rtl/register_bit.sv | 74 +++++++
 tb/tb_register_bit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bit.sv
`default_nettype none
// ============================================================================
// Module   : register_bit
// Purpose  : WIDTH-bit register with load, shift left/right, sync clear,
//            serial out and zero/parity status flags.
// Revision : 1.0 - initial release
// ============================================================================
module register_bit #(
  parameter int                 WIDTH       = 7,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic             sout,
  output logic             zero,
  output logic             parity
);

  localparam logic [1:0] c_mode_hold  = 2'b00;
  localparam logic [1:0] c_mode_load  = 2'b01;
  localparam logic [1:0] c_mode_shl   = 2'b10;
  localparam logic [1:0] c_mode_shr   = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sout;

  // Clear outranks enable; with enable low the register simply holds.
  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = RESET_VALUE;
    end else if (en) begin
      case (mode)
        c_mode_hold: w_q_next = r_q;
        c_mode_load: w_q_next = d;
        c_mode_shl:  w_q_next = {r_q[WIDTH-2:0], sin};
        c_mode_shr:  w_q_next = {sin, r_q[WIDTH-1:1]};
        default:     w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Serial output shows the bit that the selected shift would push out.
  always_comb begin
    w_sout = 1'b0;
    case (mode)
      c_mode_shl: w_sout = r_q[WIDTH-1];
      c_mode_shr: w_sout = r_q[0];
      default:    w_sout = 1'b0;
    endcase
  end

  assign q      = r_q;
  assign sout   = w_sout;
  assign zero   = ~|r_q;
  assign parity = ^r_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bit.sv
`default_nettype none
// Directed self-checking bench for register_bit (WIDTH=7, RESET_VALUE=0).
module tb_register_bit;

  logic       clk;
  logic       res;
  logic [6:0] d;
  logic [6:0] q;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic       sin;
  logic       sout;
  logic       zero;
  logic       parity;

  int total;
  int bad;

  register_bit dut (
    .clk    (clk),
    .res    (res),
    .d      (d),
    .q      (q),
    .en     (en),
    .clr    (clr),
    .mode   (mode),
    .sin    (sin),
    .sout   (sout),
    .zero   (zero),
    .parity (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL reset_q: got %b want %b", q, 7'b0000000); end
    total++;
    if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
    total++;
    if (parity !== 1'b0) begin bad++; $display("FAIL reset_parity: got %b want 0", parity); end
    #1;
    res = 1'b1;
  endtask

  task automatic test_load();
    en = 1'b1; mode = 2'b01; d = 7'b0000111;
    tick();
    total++;
    if (q !== 7'b0000111) begin bad++; $display("FAIL load_q: got %b want %b", q, 7'b0000111); end
    total++;
    if (zero !== 1'b0) begin bad++; $display("FAIL load_zero: got %b want 0", zero); end
    total++;
    if (parity !== 1'b1) begin bad++; $display("FAIL load_parity: got %b want 1", parity); end
  endtask

  task automatic test_shift_left();
    mode = 2'b10; sin = 1'b1; d = 7'b1111111;
    #1;
    total++;
    if (sout !== 1'b0) begin bad++; $display("FAIL shl_sout_pre: got %b want 0", sout); end
    tick();
    total++;
    if (q !== 7'b0001111) begin bad++; $display("FAIL shl_q: got %b want %b", q, 7'b0001111); end
    total++;
    if (parity !== 1'b0) begin bad++; $display("FAIL shl_parity: got %b want 0", parity); end
  endtask

  task automatic test_shift_right();
    mode = 2'b11; sin = 1'b0;
    #1;
    total++;
    if (sout !== 1'b1) begin bad++; $display("FAIL shr_sout_pre1: got %b want 1", sout); end
    tick();
    total++;
    if (q !== 7'b0000111) begin bad++; $display("FAIL shr_q1: got %b want %b", q, 7'b0000111); end
    total++;
    if (sout !== 1'b1) begin bad++; $display("FAIL shr_sout_pre2: got %b want 1", sout); end
    tick();
    total++;
    if (q !== 7'b0000011) begin bad++; $display("FAIL shr_q2: got %b want %b", q, 7'b0000011); end
  endtask

  task automatic test_clear_hold();
    clr = 1'b1; en = 1'b0;
    tick();
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL clr_q: got %b want %b", q, 7'b0000000); end
    clr = 1'b0; en = 1'b0; mode = 2'b01; d = 7'b1111111;
    #1;
    total++;
    if (sout !== 1'b0) begin bad++; $display("FAIL load_mode_sout: got %b want 0", sout); end
    tick();
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL hold_en0_q: got %b want %b", q, 7'b0000000); end
    // Clear beats an enabled load.
    en = 1'b1; d = 7'b1010101;
    tick();
    clr = 1'b1; d = 7'b1111111;
    tick();
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL clr_prio_q: got %b want %b", q, 7'b0000000); end
    clr = 1'b0; d = 7'b0110011;
    tick();
    mode = 2'b00; d = 7'b1111111;
    #1;
    total++;
    if (sout !== 1'b0) begin bad++; $display("FAIL hold_mode_sout: got %b want 0", sout); end
    tick();
    total++;
    if (q !== 7'b0110011) begin bad++; $display("FAIL mode00_hold_q: got %b want %b", q, 7'b0110011); end
  endtask

  task automatic test_shift_boundary();
    en = 1'b1; mode = 2'b01; d = 7'b1000001;
    tick();
    mode = 2'b11; sin = 1'b1;
    tick();
    total++;
    if (q !== 7'b1100000) begin bad++; $display("FAIL shr_nowrap_q: got %b want %b", q, 7'b1100000); end
    mode = 2'b01; d = 7'b1000001;
    tick();
    mode = 2'b10; sin = 1'b0;
    #1;
    total++;
    if (sout !== 1'b1) begin bad++; $display("FAIL shl_msb_sout: got %b want 1", sout); end
    tick();
    total++;
    if (q !== 7'b0000010) begin bad++; $display("FAIL shl_nowrap_q: got %b want %b", q, 7'b0000010); end
  endtask

  task automatic test_between_edges();
    en = 1'b1; mode = 2'b01; d = 7'b0011100;
    tick();
    d = 7'b1111111; mode = 2'b10; sin = 1'b1; clr = 1'b1;
    #2;
    d = 7'b0000001; mode = 2'b11; clr = 1'b0; en = 1'b0;
    #1;
    total++;
    if (q !== 7'b0011100) begin bad++; $display("FAIL between_edges_q: got %b want %b", q, 7'b0011100); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 2'b01; d = 7'b1010101; clr = 1'b0;
    tick();
    total++;
    if (parity !== 1'b0) begin bad++; $display("FAIL load55_parity: got %b want 0", parity); end
    mode = 2'b10; sin = 1'b1;
    #3;
    res = 1'b0;
    #1;
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL async_rst_q: got %b want %b", q, 7'b0000000); end
    total++;
    if (zero !== 1'b1) begin bad++; $display("FAIL async_rst_zero: got %b want 1", zero); end
    mode = 2'b01; d = 7'b1111111;
    tick();
    tick();
    total++;
    if (q !== 7'b0000000) begin bad++; $display("FAIL rst_held_q: got %b want %b", q, 7'b0000000); end
    #2;
    res = 1'b1;
    d = 7'b0101010;
    tick();
    total++;
    if (q !== 7'b0101010) begin bad++; $display("FAIL post_rst_load_q: got %b want %b", q, 7'b0101010); end
    total++;
    if (parity !== 1'b1) begin bad++; $display("FAIL post_rst_parity: got %b want 1", parity); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    res   = 1'b0;
    d     = 7'b0000000;
    en    = 1'b0;
    clr   = 1'b0;
    mode  = 2'b00;
    sin   = 1'b0;
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_clear_hold();
    test_shift_boundary();
    test_between_edges();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
